mips_bus_sequencer: RTL and testbench
=====================================

Name:
mips_bus_sequencer

Overview:
- Sequencer between the Harvard-style MIPS core and a single shared Avalon-style memory bus with waitrequest.
- Per core instruction, serialises one instruction fetch and at most one data access onto the bus.
- Holds the fetched instruction and loaded data in registers.
- Advances the core by pulsing its clock enable for exactly one cycle per instruction.
- Generalises the fixed 32-bit harvard interface to parametrised address/data width with byte enables.

Parameters:
ADDR_W, 32, bus and core address width
DATA_W, 32, bus and core data width; multiple of 8, power of two
TIMEOUT_CYCLES, 255, waitrequest-high cycles tolerated per access (used only with MIPS_BUS_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_clk_enable  out  1  one-cycle pulse that advances the core
cpu_active  in  1  core active flag; low means core has finished
instr_address  in  ADDR_W  core fetch address
instr_readdata  out  DATA_W  registered fetched instruction
data_read  in  1  core load request
data_write  in  1  core store request
data_address  in  ADDR_W  core data address
data_writedata  in  DATA_W  core store data
data_byteenable  in  DATA_W/8  core store/load byte lanes
data_readdata  out  DATA_W  registered load data
address  out  ADDR_W  bus address, lane-aligned
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  DATA_W  bus write data
byteenable  out  DATA_W/8  bus byte lanes
waitrequest  in  1  bus stall
readdata  in  DATA_W  bus read data
bus_error  out  1  sticky error flag
halted  out  1  high in HALT state

Behaviour:
- Reset (sync, clk rising edge):
  - State IDLE.
  - All outputs 0: read, write, cpu_clk_enable, bus_error, halted, instr_readdata, data_readdata, address, writedata, byteenable.
  - Reset asserted mid-access drops read/write at that edge; the access is abandoned with no retry.
- States: IDLE, FETCH, DECODE, DATA, STEP, HALT.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - address = instr_address with low log2(DATA_W/8) bits cleared; read=1; byteenable all ones.
  - While waitrequest=1: hold all bus outputs stable.
  - On waitrequest=0: instr_readdata <= readdata; go to DECODE.
- DECODE: bus idle; core settles on the new instruction. Sample data_read/data_write:
  - read only or write only → DATA.
  - neither → STEP.
  - both → set bus_error, no bus access, → STEP.
- DATA:
  - address = data_address lane-aligned; read=data_read; write=data_write; writedata=data_writedata; byteenable=data_byteenable.
  - Values are captured at DECODE exit and held stable until waitrequest=0.
  - On completion of a read: data_readdata <= readdata; data_readdata is otherwise unchanged.
  - → STEP.
- STEP:
  - cpu_clk_enable=1 for this cycle only.
  - Next state: FETCH if cpu_active=1, else HALT.
- HALT:
  - halted=1; bus idle; cpu_clk_enable=0.
  - Left only via reset.
- Latency with waitrequest never high:
  - 3 cycles per non-memory instruction (FETCH, DECODE, STEP).
  - 4 cycles per memory instruction.
  - Each waitrequest-high cycle adds one cycle.
- cpu_clk_enable is never high outside STEP. read and write are never both high.
- bus_error is sticky until reset.

Optional Feature:
- Macro: MIPS_BUS_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to FETCH/DATA.
  - It increments each cycle waitrequest=1 in those states.
  - When it reaches TIMEOUT_CYCLES with waitrequest still 1: deassert read/write next edge, set bus_error, load the destination register (instr_readdata or data_readdata) with all ones, → HALT.
- Without the macro: no counter is instantiated, the sequencer waits indefinitely, and bus_error is set only by simultaneous read+write.

Test Plan:
- Zero-wait fetch, non-memory instruction: readdata=0x24020005, waitrequest=0 → instr_readdata=0x24020005 after FETCH; cpu_clk_enable pulses exactly once every 3 cycles.
- Load with 2 wait cycles: data_read=1, data_address=0x1006, readdata=0xDEADBEEF → address=0x1004 held stable 3 cycles; data_readdata=0xDEADBEEF; STEP 6 cycles after FETCH entry.
- Store: data_write=1, data_writedata=0x12345678, byteenable=4'b0011 → one cycle write=1 with those values; read=0 throughout DATA.
- data_read=data_write=1 at DECODE → no bus strobe, bus_error=1, cpu_clk_enable still pulses once.
- cpu_active=0 at STEP → HALT, halted=1, no further read; then reset=1 for 1 cycle → all outputs 0, fetch resumes 2 cycles later.
- With MIPS_BUS_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high in FETCH → read drops after 4 stall cycles, bus_error=1, instr_readdata=all ones, halted=1.

Source files
------------

// File: rtl/mips_bus_sequencer_if.sv
// Avalon-style shared memory bus between the MIPS sequencer (master) and memory (slave).
interface mips_bus_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_sequencer.sv
// Serialises one fetch and at most one data access per MIPS instruction onto a shared bus.
// Optional stall watchdog enabled by defining MIPS_BUS_SEQ_TIMEOUT_EN.
module mips_bus_sequencer #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  output logic                cpu_clk_enable,
  input  logic                cpu_active,
  input  logic [ADDR_W-1:0]   instr_address,
  output logic [DATA_W-1:0]   instr_readdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic [DATA_W-1:0]   data_writedata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_readdata,
  mips_bus_sequencer_if.master bus,
  output logic                bus_error,
  output logic                halted
);
  localparam int BE_W      = DATA_W / 8;
  localparam int LANE_BITS = $clog2(BE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DATA, S_STEP, S_HALT
  } state_t;

  if (((DATA_W % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("mips_bus_sequencer: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  logic [ADDR_W-1:0] lane_mask;
  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_lane_mask
    assign lane_mask[gi] = (gi >= LANE_BITS);
  end

  state_t            state_reg;
  logic [ADDR_W-1:0] address_reg;
  logic              read_reg;
  logic              write_reg;
  logic [DATA_W-1:0] writedata_reg;
  logic [BE_W-1:0]   byteenable_reg;
  logic [DATA_W-1:0] instr_readdata_reg;
  logic [DATA_W-1:0] data_readdata_reg;
  logic              cpu_clk_enable_reg;
  logic              bus_error_reg;
  logic              halted_reg;
  logic              timeout;

`ifdef MIPS_BUS_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_reg;

  // FETCH and DATA are always entered from another state, so clearing outside them clears on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg != S_FETCH) && (state_reg != S_DATA)) begin
      stall_cnt_reg <= '0;
    end else if (bus.waitrequest) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign timeout = bus.waitrequest && (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      address_reg        <= '0;
      read_reg           <= 1'b0;
      write_reg          <= 1'b0;
      writedata_reg      <= '0;
      byteenable_reg     <= '0;
      instr_readdata_reg <= '0;
      data_readdata_reg  <= '0;
      cpu_clk_enable_reg <= 1'b0;
      bus_error_reg      <= 1'b0;
      halted_reg         <= 1'b0;
    end else begin
      cpu_clk_enable_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          read_reg       <= 1'b1;
          byteenable_reg <= '1;
          state_reg      <= S_FETCH;
        end
        S_FETCH: begin
          if (timeout) begin
            read_reg           <= 1'b0;
            byteenable_reg     <= '0;
            bus_error_reg      <= 1'b1;
            instr_readdata_reg <= '1;
            halted_reg         <= 1'b1;
            state_reg          <= S_HALT;
          end else if (!bus.waitrequest) begin
            instr_readdata_reg <= bus.readdata;
            read_reg           <= 1'b0;
            byteenable_reg     <= '0;
            state_reg          <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (data_read && data_write) begin
            bus_error_reg      <= 1'b1;
            cpu_clk_enable_reg <= 1'b1;
            state_reg          <= S_STEP;
          end else if (data_read || data_write) begin
            address_reg    <= data_address & lane_mask;
            read_reg       <= data_read;
            write_reg      <= data_write;
            writedata_reg  <= data_writedata;
            byteenable_reg <= data_byteenable;
            state_reg      <= S_DATA;
          end else begin
            cpu_clk_enable_reg <= 1'b1;
            state_reg          <= S_STEP;
          end
        end
        S_DATA: begin
          if (timeout) begin
            if (read_reg) begin
              data_readdata_reg <= '1;
            end
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            byteenable_reg <= '0;
            bus_error_reg  <= 1'b1;
            halted_reg     <= 1'b1;
            state_reg      <= S_HALT;
          end else if (!bus.waitrequest) begin
            if (read_reg) begin
              data_readdata_reg <= bus.readdata;
            end
            read_reg           <= 1'b0;
            write_reg          <= 1'b0;
            byteenable_reg     <= '0;
            cpu_clk_enable_reg <= 1'b1;
            state_reg          <= S_STEP;
          end
        end
        S_STEP: begin
          if (cpu_active) begin
            read_reg       <= 1'b1;
            byteenable_reg <= '1;
            state_reg      <= S_FETCH;
          end else begin
            halted_reg <= 1'b1;
            state_reg  <= S_HALT;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // The core PC only changes on the STEP edge, so it is stable for the whole fetch;
  // using it directly avoids capturing the pre-step PC on that same edge.
  assign bus.address    = (state_reg == S_FETCH) ? (instr_address & lane_mask) : address_reg;
  assign bus.read       = read_reg;
  assign bus.write      = write_reg;
  assign bus.writedata  = writedata_reg;
  assign bus.byteenable = byteenable_reg;

  assign cpu_clk_enable = cpu_clk_enable_reg;
  assign instr_readdata = instr_readdata_reg;
  assign data_readdata  = data_readdata_reg;
  assign bus_error      = bus_error_reg;
  assign halted         = halted_reg;
endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Directed scoreboard bench for mips_bus_sequencer acting as both core and bus slave.
module tb_mips_bus_sequencer;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          waits;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        bus_error;
  logic        halted;

  bus_exp_t    bus_q[$];
  logic [31:0] exp_dread;
  logic        exp_err;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          sn;

  always #5 clk = ~clk;

  mips_bus_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  mips_bus_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_clk_enable(cpu_clk_enable),
    .cpu_active(cpu_active),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .data_read(data_read),
    .data_write(data_write),
    .data_address(data_address),
    .data_writedata(data_writedata),
    .data_byteenable(data_byteenable),
    .data_readdata(data_readdata),
    .bus(bus_if),
    .bus_error(bus_error),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.waitrequest = 1'b0;
    @(negedge clk);
    check("rst_strobes", {bus_if.read, bus_if.write, cpu_clk_enable, bus_error, halted}, 0);
    check("rst_instr_readdata", instr_readdata, 0);
    check("rst_data_readdata", data_readdata, 0);
    check("rst_bus_fields", {bus_if.address, bus_if.writedata, bus_if.byteenable}, 0);
    exp_dread = '0;
    exp_err   = 1'b0;
    bus_q.delete();
    reset = 1'b0;
  endtask

  // One core instruction: push expected bus traffic, then serve the bus until the step pulse.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr, input int fwaits,
                           input logic rd, input logic wr, input logic [31:0] daddr,
                           input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata,
                           input int dwaits, input logic active, input int exp_cyc,
                           output int start_n);
    bus_exp_t e;
    bus_exp_t cur;
    int cyc = 0;
    int wait_left = 0;
    int bad_excl = 0;
    int bad_stable = 0;
    int bad_pulse = 0;
    int unexpected = 0;
    bit started = 0;
    bit done = 0;
    bit in_acc = 0;
    logic [31:0] acc_addr = '0;
    start_n = -1;
    cur = '{addr: 0, rd: 0, wr: 0, wdata: 0, be: 0, rdata: 0, waits: 0};
    instr_address   = pc;
    data_read       = rd;
    data_write      = wr;
    data_address    = daddr;
    data_writedata  = wdata;
    data_byteenable = be;
    cpu_active      = 1'b1;
    bus_if.waitrequest = 1'b0;
    e = '{addr: pc & 32'hFFFF_FFFC, rd: 1'b1, wr: 1'b0, wdata: 0, be: 4'hF, rdata: instr, waits: fwaits};
    bus_q.push_back(e);
    if (rd ^ wr) begin
      e = '{addr: daddr & 32'hFFFF_FFFC, rd: rd, wr: wr, wdata: wdata, be: be, rdata: rdata, waits: dwaits};
      bus_q.push_back(e);
      if (rd) exp_dread = rdata;
    end
    if (rd && wr) exp_err = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!started && (bus_if.read || bus_if.write)) begin
        started = 1;
        start_n = n;
        cpu_active = active;
      end
      if (started) cyc++;
      if (bus_if.read && bus_if.write) bad_excl++;
      if (cpu_clk_enable && !started) bad_pulse++;
      if (bus_if.read || bus_if.write) begin
        if (!in_acc) begin
          in_acc   = 1;
          acc_addr = bus_if.address;
          if (bus_q.size() == 0) begin
            unexpected++;
            cur.waits = 0;
          end else begin
            cur = bus_q[0];
          end
          wait_left = cur.waits;
        end else if (bus_if.address !== acc_addr) begin
          bad_stable++;
        end
        if (wait_left > 0) begin
          bus_if.waitrequest = 1'b1;
          bus_if.readdata    = $urandom;
          wait_left--;
        end else begin
          bus_if.waitrequest = 1'b0;
          bus_if.readdata    = cur.rdata;
          in_acc = 0;
          if (bus_q.size() > 0) begin
            void'(bus_q.pop_front());
            check("bus_address", bus_if.address, cur.addr);
            check("bus_rw", {bus_if.read, bus_if.write}, {cur.rd, cur.wr});
            check("bus_byteenable", bus_if.byteenable, cur.be);
            if (cur.wr) check("bus_writedata", bus_if.writedata, cur.wdata);
          end
        end
      end else begin
        bus_if.waitrequest = 1'b0;
      end
      if (cpu_clk_enable && started) done = 1;
    end
    check("step_pulse_seen", done, 1);
    check("latency", cyc, exp_cyc);
    check("instr_readdata", instr_readdata, instr);
    check("data_readdata", data_readdata, exp_dread);
    check("bus_error", bus_error, exp_err);
    check("rw_exclusive", bad_excl, 0);
    check("addr_stable", bad_stable, 0);
    check("stray_pulse", bad_pulse, 0);
    check("unexpected_access", unexpected, 0);
    check("scoreboard_empty", bus_q.size(), 0);
    $display("instr pc=%08h ir=%08h rd=%0b wr=%0b cycles=%0d", pc, instr_readdata, rd, wr, cyc);
  endtask

  initial begin
    int strobes;
    cpu_active = 1'b1;
    instr_address = '0;
    data_read = 1'b0;
    data_write = 1'b0;
    data_address = '0;
    data_writedata = '0;
    data_byteenable = '0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata = '0;
    exp_dread = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    run_instr(32'h0, 32'h24020005, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, sn);
    check("fetch_after_reset", sn, 0);
    run_instr(32'h4, 32'h24030007, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, sn);
    run_instr(32'h102, 32'h00431020, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, sn);
    run_instr(32'h8, 32'h8C041006, 0, 1, 0, 32'h1006, 0, 4'hF, 32'hDEADBEEF, 2, 1, 6, sn);
    run_instr(32'hC, 32'hAC052001, 0, 0, 1, 32'h2001, 32'h12345678, 4'b0011, 0, 0, 1, 4, sn);
    run_instr(32'h10, 32'h8C063000, 1, 1, 0, 32'h3003, 0, 4'b1100, 32'hCAFEF00D, 0, 1, 5, sn);
    run_instr(32'h14, 32'hAC074000, 0, 0, 1, 32'h4000, 32'hA5A5A5A5, 4'b1000, 0, 1, 1, 5, sn);
`ifdef MIPS_BUS_SEQ_TIMEOUT_EN
    run_instr(32'h18, 32'h00000000, 3, 0, 0, 0, 0, 0, 0, 0, 1, 6, sn);
`else
    run_instr(32'h18, 32'h00000000, 10, 0, 0, 0, 0, 0, 0, 0, 1, 13, sn);
`endif
    run_instr(32'h1C, 32'h12345678, 0, 1, 1, 32'h5000, 32'h1, 4'hF, 32'h1, 0, 1, 3, sn);
    run_instr(32'h20, 32'h0000000C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, sn);

    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.read || bus_if.write || cpu_clk_enable) strobes++;
    end
    check("halted", halted, 1);
    check("halt_quiet", strobes, 0);

    do_reset();
    run_instr(32'h40, 32'h24080001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, sn);
    check("fetch_after_halt_reset", sn, 0);

`ifdef MIPS_BUS_SEQ_TIMEOUT_EN
    begin
      int rd_cycles = 0;
      int pulses = 0;
      bit dropped = 0;
      do_reset();
      instr_address = 32'h200;
      data_read = 1'b0;
      data_write = 1'b0;
      cpu_active = 1'b1;
      bus_if.waitrequest = 1'b1;
      for (int n = 0; n < 20 && !dropped; n++) begin
        @(negedge clk);
        if (bus_if.read) rd_cycles++;
        if (cpu_clk_enable) pulses++;
        if (!bus_if.read && rd_cycles > 0) dropped = 1;
      end
      check("timeout_read_cycles", rd_cycles, 4);
      check("timeout_bus_error", bus_error, 1);
      check("timeout_instr_readdata", instr_readdata, 32'hFFFF_FFFF);
      check("timeout_halted", halted, 1);
      check("timeout_no_pulse", pulses, 0);
      $display("timeout fetch read_cycles=%0d", rd_cycles);
      bus_if.waitrequest = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
